axi4l_arbiter2: RTL and testbench

//   2:1 AXI4-Lite arbiter sharing one slave (axi4l_dpramx32) between two managers (e.g. Ibex instr/data).

---
 rtl/axi4l_arbiter2_if.sv | 38 +++
 rtl/axi4l_arbiter2.sv | 199 +++++++++++++++++++
 tb/tb_axi4l_arbiter2.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4l_arbiter2_if.sv
// AXI4-Lite channel bundle shared by the arbiter, its two managers and the RAM slave.
// Address/data widths default to the 32-bit RAM slave; prot is 3 bits, resp 2 bits.
interface axi4l_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            awvalid;
    logic            awready;
    logic [AW-1:0]   awaddr;
    logic [2:0]      awprot;
    logic            wvalid;
    logic            wready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            bvalid;
    logic            bready;
    logic [1:0]      bresp;
    logic            arvalid;
    logic            arready;
    logic [AW-1:0]   araddr;
    logic [2:0]      arprot;
    logic            rvalid;
    logic            rready;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        output arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        input  arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi4l_arbiter2.sv
// 2:1 AXI4-Lite arbiter, independent write/read FSMs; AXI4L_ARB_FIXED_PRIO_EN makes manager 0 win ties.
// Latency: 1 cycle grant decision in IDLE, then address/data/response paths are combinational.
// Backpressure: ready/valid pass straight through to the granted manager; the loser sees all zeros.
module axi4l_arbiter2 #(
    parameter logic PRIO_RESET = 1'b0
) (
    input  logic     aclk,
    input  logic     aresetn,
    axi4l_if.slave   s0,
    axi4l_if.slave   s1,
    axi4l_if.master  m
);
    typedef enum logic [1:0] {IDLE, ADDR, RESP} state_e;

    state_e wr_state_q, wr_state_d, rd_state_q, rd_state_d;
    logic   wr_gnt_q, wr_gnt_d, rd_gnt_q, rd_gnt_d;
    logic   aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic   wr_tie_gnt, rd_tie_gnt;
    logic   aw_rdy, w_rdy, aw_fire, w_fire;

`ifdef AXI4L_ARB_FIXED_PRIO_EN
    assign wr_tie_gnt = 1'b0;
    assign rd_tie_gnt = 1'b0;
`else
    logic   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    assign wr_tie_gnt = wr_ptr_q;
    assign rd_tie_gnt = rd_ptr_q;
`endif

    logic wr_req0, wr_req1, rd_req0, rd_req1;
    logic g_awvalid, g_wvalid, g_bready, g_arvalid, g_rready;

    assign wr_req0   = s0.awvalid | s0.wvalid;
    assign wr_req1   = s1.awvalid | s1.wvalid;
    assign rd_req0   = s0.arvalid;
    assign rd_req1   = s1.arvalid;
    assign g_awvalid = wr_gnt_q ? s1.awvalid : s0.awvalid;
    assign g_wvalid  = wr_gnt_q ? s1.wvalid  : s0.wvalid;
    assign g_bready  = wr_gnt_q ? s1.bready  : s0.bready;
    assign g_arvalid = rd_gnt_q ? s1.arvalid : s0.arvalid;
    assign g_rready  = rd_gnt_q ? s1.rready  : s0.rready;

    always_comb begin
        wr_state_d = wr_state_q;
        wr_gnt_d   = wr_gnt_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
`ifndef AXI4L_ARB_FIXED_PRIO_EN
        wr_ptr_d   = wr_ptr_q;
`endif
        aw_rdy     = 1'b0;
        w_rdy      = 1'b0;
        aw_fire    = 1'b0;
        w_fire     = 1'b0;
        s0.awready = 1'b0;
        s0.wready  = 1'b0;
        s0.bvalid  = 1'b0;
        s0.bresp   = '0;
        s1.awready = 1'b0;
        s1.wready  = 1'b0;
        s1.bvalid  = 1'b0;
        s1.bresp   = '0;
        m.awvalid  = 1'b0;
        m.wvalid   = 1'b0;
        m.bready   = 1'b0;
        // Payload follows the registered grant, so it cannot change under a pending valid.
        m.awaddr   = wr_gnt_q ? s1.awaddr : s0.awaddr;
        m.awprot   = wr_gnt_q ? s1.awprot : s0.awprot;
        m.wdata    = wr_gnt_q ? s1.wdata  : s0.wdata;
        m.wstrb    = wr_gnt_q ? s1.wstrb  : s0.wstrb;
        case (wr_state_q)
            IDLE: begin
                if (wr_req0 | wr_req1) begin
                    wr_gnt_d   = (wr_req0 & wr_req1) ? wr_tie_gnt : wr_req1;
                    wr_state_d = ADDR;
                end
            end
            ADDR: begin
                m.awvalid = g_awvalid & ~aw_done_q;
                m.wvalid  = g_wvalid & ~w_done_q;
                aw_rdy    = m.awready & ~aw_done_q;
                w_rdy     = m.wready & ~w_done_q;
                aw_fire   = g_awvalid & aw_rdy;
                w_fire    = g_wvalid & w_rdy;
                if (wr_gnt_q) begin
                    s1.awready = aw_rdy;
                    s1.wready  = w_rdy;
                end else begin
                    s0.awready = aw_rdy;
                    s0.wready  = w_rdy;
                end
                if ((aw_done_q | aw_fire) & (w_done_q | w_fire)) begin
                    wr_state_d = RESP;
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                end else begin
                    aw_done_d  = aw_done_q | aw_fire;
                    w_done_d   = w_done_q | w_fire;
                end
            end
            RESP: begin
                m.bready = g_bready;
                if (wr_gnt_q) begin
                    s1.bvalid = m.bvalid;
                    s1.bresp  = m.bresp;
                end else begin
                    s0.bvalid = m.bvalid;
                    s0.bresp  = m.bresp;
                end
                if (m.bvalid & g_bready) begin
                    wr_state_d = IDLE;
`ifndef AXI4L_ARB_FIXED_PRIO_EN
                    wr_ptr_d   = ~wr_gnt_q;
`endif
                end
            end
            default: wr_state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rd_gnt_d   = rd_gnt_q;
`ifndef AXI4L_ARB_FIXED_PRIO_EN
        rd_ptr_d   = rd_ptr_q;
`endif
        s0.arready = 1'b0;
        s0.rvalid  = 1'b0;
        s0.rdata   = '0;
        s0.rresp   = '0;
        s1.arready = 1'b0;
        s1.rvalid  = 1'b0;
        s1.rdata   = '0;
        s1.rresp   = '0;
        m.arvalid  = 1'b0;
        m.rready   = 1'b0;
        m.araddr   = rd_gnt_q ? s1.araddr : s0.araddr;
        m.arprot   = rd_gnt_q ? s1.arprot : s0.arprot;
        case (rd_state_q)
            IDLE: begin
                if (rd_req0 | rd_req1) begin
                    rd_gnt_d   = (rd_req0 & rd_req1) ? rd_tie_gnt : rd_req1;
                    rd_state_d = ADDR;
                end
            end
            ADDR: begin
                m.arvalid = g_arvalid;
                if (rd_gnt_q) s1.arready = m.arready;
                else          s0.arready = m.arready;
                if (g_arvalid & m.arready) rd_state_d = RESP;
            end
            RESP: begin
                m.rready = g_rready;
                if (rd_gnt_q) begin
                    s1.rvalid = m.rvalid;
                    s1.rdata  = m.rdata;
                    s1.rresp  = m.rresp;
                end else begin
                    s0.rvalid = m.rvalid;
                    s0.rdata  = m.rdata;
                    s0.rresp  = m.rresp;
                end
                if (m.rvalid & g_rready) begin
                    rd_state_d = IDLE;
`ifndef AXI4L_ARB_FIXED_PRIO_EN
                    rd_ptr_d   = ~rd_gnt_q;
`endif
                end
            end
            default: rd_state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_state_q <= IDLE;
            rd_state_q <= IDLE;
            wr_gnt_q   <= 1'b0;
            rd_gnt_q   <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
`ifndef AXI4L_ARB_FIXED_PRIO_EN
            wr_ptr_q   <= PRIO_RESET;
            rd_ptr_q   <= PRIO_RESET;
`endif
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            wr_gnt_q   <= wr_gnt_d;
            rd_gnt_q   <= rd_gnt_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
`ifndef AXI4L_ARB_FIXED_PRIO_EN
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
`endif
        end
    end
endmodule

// File: tb/tb_axi4l_arbiter2.sv
// Directed bench for axi4l_arbiter2: two scripted managers and a small single-outstanding RAM slave.
module tb_axi4l_arbiter2;
    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    axi4l_if s0_if ();
    axi4l_if s1_if ();
    axi4l_if m_if ();

    axi4l_arbiter2 #(.PRIO_RESET(1'b0)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .s0      (s0_if),
        .s1      (s1_if),
        .m       (m_if)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] mem [0:15];
    logic        slv_aw_seen, slv_w_seen;
    logic [31:0] slv_aw_a, slv_w_d;
    logic [1:0]  slv_bresp;
    int          wr_order[$];
    int          m_aw_cnt, m_w_cnt;
    int          b_cnt[2];
    int          r_cnt[2];
    int          wr_left[2];
    logic [31:0] rd_got[2];

    task automatic clear_inputs();
        s0_if.awvalid = 0; s0_if.wvalid = 0; s0_if.arvalid = 0;
        s1_if.awvalid = 0; s1_if.wvalid = 0; s1_if.arvalid = 0;
        m_if.bvalid = 0; m_if.rvalid = 0;
        slv_aw_seen = 0; slv_w_seen = 0;
    endtask

    // One clock: note handshakes visible now, cross the edge, update managers and slave.
    task automatic step();
        logic s0aw, s0w, s0ar, s1aw, s1w, s1ar, s0b, s1b, maw, mw, mb, mar, mr;
        logic [31:0] maw_a, mw_d, mar_a;
        s0aw = s0_if.awvalid & s0_if.awready;  s1aw = s1_if.awvalid & s1_if.awready;
        s0w  = s0_if.wvalid & s0_if.wready;    s1w  = s1_if.wvalid & s1_if.wready;
        s0ar = s0_if.arvalid & s0_if.arready;  s1ar = s1_if.arvalid & s1_if.arready;
        s0b  = s0_if.bvalid & s0_if.bready;    s1b  = s1_if.bvalid & s1_if.bready;
        maw  = m_if.awvalid & m_if.awready;    mw   = m_if.wvalid & m_if.wready;
        mb   = m_if.bvalid & m_if.bready;      mar  = m_if.arvalid & m_if.arready;
        mr   = m_if.rvalid & m_if.rready;
        maw_a = m_if.awaddr; mw_d = m_if.wdata; mar_a = m_if.araddr;
        if (s0_if.rvalid & s0_if.rready) begin r_cnt[0]++; rd_got[0] = s0_if.rdata; end
        if (s1_if.rvalid & s1_if.rready) begin r_cnt[1]++; rd_got[1] = s1_if.rdata; end
        @(negedge aclk);
        if (s0aw) s0_if.awvalid = 0;
        if (s0w)  s0_if.wvalid  = 0;
        if (s0ar) s0_if.arvalid = 0;
        if (s1aw) s1_if.awvalid = 0;
        if (s1w)  s1_if.wvalid  = 0;
        if (s1ar) s1_if.arvalid = 0;
        if (maw) begin m_aw_cnt++; wr_order.push_back(s1aw ? 1 : 0); slv_aw_seen = 1; slv_aw_a = maw_a; end
        if (mw)  begin m_w_cnt++; slv_w_seen = 1; slv_w_d = mw_d; end
        if (mb)  m_if.bvalid = 0;
        if (mr)  m_if.rvalid = 0;
        if (mar) begin m_if.rvalid = 1; m_if.rdata = mem[mar_a[5:2]]; m_if.rresp = 2'b00; end
        if (slv_aw_seen && slv_w_seen) begin
            mem[slv_aw_a[5:2]] = slv_w_d;
            m_if.bvalid = 1; m_if.bresp = slv_bresp;
            slv_aw_seen = 0; slv_w_seen = 0;
        end
        if (s0b) begin b_cnt[0]++; if (wr_left[0] > 0) begin wr_left[0]--; s0_if.awvalid = 1; s0_if.wvalid = 1; end end
        if (s1b) begin b_cnt[1]++; if (wr_left[1] > 0) begin wr_left[1]--; s1_if.awvalid = 1; s1_if.wvalid = 1; end end
        #1;
    endtask

    task automatic do_reset();
        aresetn = 0;
        clear_inputs();
        @(negedge aclk);
        aresetn = 1;
        #1;
    endtask

    task automatic test_reset();
        s0_if.awvalid = 1; s1_if.arvalid = 1; m_if.bvalid = 1; m_if.rvalid = 1; m_if.rdata = 32'hFFFF_FFFF;
        #1;
        if ({s0_if.awready, s0_if.wready, s0_if.arready, s0_if.bvalid, s0_if.rvalid,
             s1_if.awready, s1_if.wready, s1_if.arready, s1_if.bvalid, s1_if.rvalid,
             m_if.awvalid, m_if.wvalid, m_if.arvalid, m_if.bready, m_if.rready} !== 15'h0) begin
            $display("FAIL rst_outputs: handshake outputs not all zero in reset");
            n_fail++;
        end
        n_tests++;
        repeat (2) @(negedge aclk);
        #1;
        if ({m_if.awvalid, m_if.arvalid, s0_if.rdata, s1_if.rdata} !== 66'h0) begin
            $display("FAIL rst_held: got %h, expected 0", {m_if.awvalid, m_if.arvalid, s0_if.rdata, s1_if.rdata});
            n_fail++;
        end
        n_tests++;
        clear_inputs();
        @(negedge aclk);
        aresetn = 1;
        #1;
    endtask

    task automatic test_single_write();
        b_cnt[0] = 0; b_cnt[1] = 0;
        s0_if.awaddr = 32'h4; s0_if.awprot = 3'b010; s0_if.wdata = 32'hDEADBEEF; s0_if.wstrb = 4'hF;
        s0_if.bready = 1; s0_if.awvalid = 1; s0_if.wvalid = 1;
        #1;
        if ({m_if.awvalid, m_if.wvalid, s0_if.awready} !== 3'b000) begin
            $display("FAIL w1_idle: got %b, expected 000", {m_if.awvalid, m_if.wvalid, s0_if.awready});
            n_fail++;
        end
        n_tests++;
        step();
        if ({m_if.awvalid, m_if.wvalid, m_if.awaddr, m_if.awprot, m_if.wdata, m_if.wstrb,
             s0_if.awready, s0_if.wready, s1_if.awready, s1_if.wready} !==
            {1'b1, 1'b1, 32'h4, 3'b010, 32'hDEADBEEF, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            $display("FAIL w1_fwd: got %h, expected %h",
                {m_if.awvalid, m_if.wvalid, m_if.awaddr, m_if.awprot, m_if.wdata, m_if.wstrb,
                 s0_if.awready, s0_if.wready, s1_if.awready, s1_if.wready},
                {1'b1, 1'b1, 32'h4, 3'b010, 32'hDEADBEEF, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0});
            n_fail++;
        end
        n_tests++;
        step();
        if ({s0_if.bvalid, s0_if.bresp, s1_if.bvalid, m_if.bready, m_if.awvalid, m_if.wvalid} !== 7'b1_00_0_1_0_0) begin
            $display("FAIL w1_resp: got %b, expected 1000100",
                {s0_if.bvalid, s0_if.bresp, s1_if.bvalid, m_if.bready, m_if.awvalid, m_if.wvalid});
            n_fail++;
        end
        n_tests++;
        step();
        if (s0_if.bvalid !== 1'b0 || m_if.bready !== 1'b0 || b_cnt[0] !== 1 || b_cnt[1] !== 0) begin
            $display("FAIL w1_done: bvalid %b bready %b b0 %0d b1 %0d, expected 0 0 1 0",
                s0_if.bvalid, m_if.bready, b_cnt[0], b_cnt[1]);
            n_fail++;
        end
        n_tests++;
    endtask

    task automatic test_tie();
        int n;
        int exp_order[4];
`ifdef AXI4L_ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 1, 1};
`else
        exp_order = '{0, 1, 0, 1};
`endif
        do_reset();
        wr_order.delete();
        b_cnt[0] = 0; b_cnt[1] = 0; wr_left[0] = 1; wr_left[1] = 1;
        s0_if.awaddr = 32'h10; s0_if.wdata = 32'h11111111; s0_if.wstrb = 4'hF; s0_if.bready = 1;
        s1_if.awaddr = 32'h14; s1_if.wdata = 32'h22222222; s1_if.wstrb = 4'hF; s1_if.bready = 1;
        s0_if.awvalid = 1; s0_if.wvalid = 1; s1_if.awvalid = 1; s1_if.wvalid = 1;
        n = 0;
        while (b_cnt[0] + b_cnt[1] < 4 && n < 60) begin
            step();
            n++;
        end
        if (n !== 12) begin
            $display("FAIL tie_cycles: got %0d cycles for 4 writes, expected 12", n);
            n_fail++;
        end
        n_tests++;
        for (int k = 0; k < 4; k++) begin
            if (wr_order.size() <= k || wr_order[k] !== exp_order[k]) begin
                $display("FAIL tie_order[%0d]: got %0d, expected %0d", k,
                    (wr_order.size() > k) ? wr_order[k] : -1, exp_order[k]);
                n_fail++;
            end
            n_tests++;
        end
    endtask

    task automatic test_concurrent();
        mem[2] = 32'hCAFEF00D;
        b_cnt[0] = 0; b_cnt[1] = 0; r_cnt[0] = 0; r_cnt[1] = 0;
        s0_if.araddr = 32'h8; s0_if.arprot = 3'b000; s0_if.rready = 1; s0_if.arvalid = 1;
        s1_if.awaddr = 32'h8; s1_if.wdata = 32'h12345678; s1_if.wstrb = 4'hF; s1_if.bready = 1;
        s1_if.awvalid = 1; s1_if.wvalid = 1;
        step();
        if ({m_if.awvalid, m_if.arvalid, m_if.awaddr, m_if.araddr, s0_if.arready, s1_if.awready,
             s0_if.awready, s1_if.arready} !== {1'b1, 1'b1, 32'h8, 32'h8, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            $display("FAIL rw_parallel: got %h, expected %h",
                {m_if.awvalid, m_if.arvalid, m_if.awaddr, m_if.araddr, s0_if.arready, s1_if.awready,
                 s0_if.awready, s1_if.arready}, {1'b1, 1'b1, 32'h8, 32'h8, 1'b1, 1'b1, 1'b0, 1'b0});
            n_fail++;
        end
        n_tests++;
        step();
        if ({s0_if.rvalid, s0_if.rdata, s1_if.rvalid, s1_if.rdata, s1_if.bvalid, s0_if.bvalid} !==
            {1'b1, 32'hCAFEF00D, 1'b0, 32'h0, 1'b1, 1'b0}) begin
            $display("FAIL rw_route: got %h, expected %h",
                {s0_if.rvalid, s0_if.rdata, s1_if.rvalid, s1_if.rdata, s1_if.bvalid, s0_if.bvalid},
                {1'b1, 32'hCAFEF00D, 1'b0, 32'h0, 1'b1, 1'b0});
            n_fail++;
        end
        n_tests++;
        step();
        if (r_cnt[0] !== 1 || r_cnt[1] !== 0 || b_cnt[0] !== 0 || b_cnt[1] !== 1 || rd_got[0] !== 32'hCAFEF00D) begin
            $display("FAIL rw_counts: r0 %0d r1 %0d b0 %0d b1 %0d data %h, expected 1 0 0 1 cafef00d",
                r_cnt[0], r_cnt[1], b_cnt[0], b_cnt[1], rd_got[0]);
            n_fail++;
        end
        n_tests++;
        s1_if.araddr = 32'h8; s1_if.rready = 1; s1_if.arvalid = 1;
        step();
        step();
        if ({s1_if.rvalid, s1_if.rdata, s0_if.rvalid, s0_if.rdata} !== {1'b1, 32'h12345678, 1'b0, 32'h0}) begin
            $display("FAIL rd_s1_route: got %h, expected %h",
                {s1_if.rvalid, s1_if.rdata, s0_if.rvalid, s0_if.rdata}, {1'b1, 32'h12345678, 1'b0, 32'h0});
            n_fail++;
        end
        n_tests++;
        step();
    endtask

    task automatic test_w_before_aw();
        int n;
        m_aw_cnt = 0; m_w_cnt = 0; b_cnt[0] = 0; b_cnt[1] = 0;
        slv_bresp = 2'b10;
        s1_if.awaddr = 32'h18; s1_if.wdata = 32'hA5A5A5A5; s1_if.wstrb = 4'h3; s1_if.bready = 0;
        s1_if.wvalid = 1;
        step();
        if ({m_if.wvalid, m_if.awvalid, m_if.wdata, m_if.wstrb, s1_if.wready} !==
            {1'b1, 1'b0, 32'hA5A5A5A5, 4'h3, 1'b1}) begin
            $display("FAIL wfirst_fwd: got %h, expected %h",
                {m_if.wvalid, m_if.awvalid, m_if.wdata, m_if.wstrb, s1_if.wready},
                {1'b1, 1'b0, 32'hA5A5A5A5, 4'h3, 1'b1});
            n_fail++;
        end
        n_tests++;
        step();
        s0_if.awaddr = 32'h1C; s0_if.wdata = 32'h0BADF00D; s0_if.wstrb = 4'hF; s0_if.bready = 1;
        s0_if.awvalid = 1; s0_if.wvalid = 1;
        step();
        if ({m_if.wvalid, m_if.awvalid, s0_if.awready, s0_if.wready, s1_if.wready} !== 5'b0) begin
            $display("FAIL wfirst_hold: got %b, expected 00000",
                {m_if.wvalid, m_if.awvalid, s0_if.awready, s0_if.wready, s1_if.wready});
            n_fail++;
        end
        n_tests++;
        s1_if.awvalid = 1;
        #1;
        if ({m_if.awvalid, m_if.awaddr, s1_if.awready, s0_if.awready} !== {1'b1, 32'h18, 1'b1, 1'b0}) begin
            $display("FAIL aw_late: got %h, expected %h",
                {m_if.awvalid, m_if.awaddr, s1_if.awready, s0_if.awready}, {1'b1, 32'h18, 1'b1, 1'b0});
            n_fail++;
        end
        n_tests++;
        for (int k = 0; k < 2; k++) begin
            step();
            if ({s1_if.bvalid, s1_if.bresp, m_if.bready, s0_if.bvalid} !== 5'b1_10_0_0) begin
                $display("FAIL bhold[%0d]: got %b, expected 11000", k,
                    {s1_if.bvalid, s1_if.bresp, m_if.bready, s0_if.bvalid});
                n_fail++;
            end
            n_tests++;
        end
        s1_if.bready = 1;
        step();
        slv_bresp = 2'b00;
        if (m_aw_cnt !== 1 || m_w_cnt !== 1 || b_cnt[1] !== 1) begin
            $display("FAIL single_m_write: aw %0d w %0d b1 %0d, expected 1 1 1", m_aw_cnt, m_w_cnt, b_cnt[1]);
            n_fail++;
        end
        n_tests++;
        n = 0;
        while (b_cnt[0] < 1 && n < 20) begin
            step();
            n++;
        end
        if (b_cnt[0] !== 1 || mem[7] !== 32'h0BADF00D) begin
            $display("FAIL s0_after_hold: b0 %0d mem %h, expected 1 0badf00d", b_cnt[0], mem[7]);
            n_fail++;
        end
        n_tests++;
    endtask

    task automatic test_reset_mid();
        s0_if.awaddr = 32'h20; s0_if.wdata = 32'h1; s0_if.wstrb = 4'hF; s0_if.bready = 0;
        s0_if.awvalid = 1; s0_if.wvalid = 1;
        step();
        step();
        if (s0_if.bvalid !== 1'b1) begin
            $display("FAIL rst_pre: s0 bvalid %b, expected 1", s0_if.bvalid);
            n_fail++;
        end
        n_tests++;
        s0_if.bready = 1;
        aresetn = 0;
        #1;
        if ({s0_if.bvalid, s0_if.awready, s1_if.bvalid, m_if.bready, m_if.awvalid, m_if.wvalid, m_if.arvalid} !== 7'b0) begin
            $display("FAIL rst_mid: got %b, expected 0000000",
                {s0_if.bvalid, s0_if.awready, s1_if.bvalid, m_if.bready, m_if.awvalid, m_if.wvalid, m_if.arvalid});
            n_fail++;
        end
        n_tests++;
        clear_inputs();
        @(negedge aclk);
        aresetn = 1;
        #1;
        s1_if.araddr = 32'h4; s1_if.rready = 1; s1_if.arvalid = 1;
        #1;
        if (m_if.arvalid !== 1'b0) begin
            $display("FAIL post_rst_idle: m arvalid %b, expected 0", m_if.arvalid);
            n_fail++;
        end
        n_tests++;
        step();
        if ({m_if.arvalid, m_if.araddr, s1_if.arready} !== {1'b1, 32'h4, 1'b1}) begin
            $display("FAIL post_rst_grant: got %h, expected %h",
                {m_if.arvalid, m_if.araddr, s1_if.arready}, {1'b1, 32'h4, 1'b1});
            n_fail++;
        end
        n_tests++;
        step();
        if ({s1_if.rvalid, s1_if.rdata} !== {1'b1, 32'hDEADBEEF}) begin
            $display("FAIL post_rst_data: got %h, expected %h", {s1_if.rvalid, s1_if.rdata}, {1'b1, 32'hDEADBEEF});
            n_fail++;
        end
        n_tests++;
        step();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        slv_bresp = 2'b00;
        wr_left[0] = 0; wr_left[1] = 0;
        b_cnt[0] = 0; b_cnt[1] = 0; r_cnt[0] = 0; r_cnt[1] = 0;
        rd_got[0] = '0; rd_got[1] = '0;
        m_aw_cnt = 0; m_w_cnt = 0;
        clear_inputs();
        s0_if.awaddr = '0; s0_if.awprot = '0; s0_if.wdata = '0; s0_if.wstrb = '0; s0_if.bready = 0;
        s0_if.araddr = '0; s0_if.arprot = '0; s0_if.rready = 0;
        s1_if.awaddr = '0; s1_if.awprot = '0; s1_if.wdata = '0; s1_if.wstrb = '0; s1_if.bready = 0;
        s1_if.araddr = '0; s1_if.arprot = '0; s1_if.rready = 0;
        m_if.awready = 1; m_if.wready = 1; m_if.arready = 1;
        m_if.bresp = '0; m_if.rresp = '0; m_if.rdata = '0;
        test_reset();
        test_single_write();
        test_tie();
        test_concurrent();
        test_w_before_aw();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
